// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back request/grant bundle and register-file write port
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                          stall;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          reg_write;
    logic [ADDR_WIDTH-1:0]         write_reg;
    logic [DATA_WIDTH-1:0]         write_data;
    logic [1:0]                    grant_id;

    modport master (
        output stall, req_valid, req_addr, req_data,
        input  req_ready, reg_write, write_reg, write_data, grant_id
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
        output req_ready, reg_write, write_reg, write_data, grant_id
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
// Define REGFILE_WB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]    w_ready;
    logic [1:0]            w_win;
    logic                  w_xfer;
    logic [1:0]            w_start;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;

    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_write_reg;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic [1:0]            r_grant_id;

    function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int offset);
        return (int'(base) + offset >= NUM_REQ) ? 2'(int'(base) + offset - NUM_REQ)
                                                : 2'(int'(base) + offset);
    endfunction

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
    assign w_start = 2'd0;
`else
    logic [1:0] r_rr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_win == LAST_IDX) ? 2'd0 : w_win + 2'd1;
        end
    end

    assign w_start = r_rr_ptr;
`endif

    // Grant depends only on valid, stall and the pointer, never on addr/data.
    always_comb begin
        w_ready = '0;
        w_win   = 2'd0;
        w_xfer  = 1'b0;
        if (!reset && !bus.stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_xfer && bus.req_valid[wrap_idx(w_start, k)]) begin
                    w_xfer = 1'b1;
                    w_win  = wrap_idx(w_start, k);
                end
            end
        end
        if (w_xfer) begin
            w_ready[w_win] = 1'b1;
        end
    end

    assign w_addr = bus.req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data = bus.req_data[w_win*DATA_WIDTH +: DATA_WIDTH];

    // R0 transfers are acknowledged and recorded but never raise reg_write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_grant_id   <= 2'd0;
        end else begin
            r_reg_write <= w_xfer && (w_addr != '0);
            if (w_xfer) begin
                r_write_reg  <= w_addr;
                r_write_data <= w_data;
                r_grant_id   <= w_win;
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.reg_write  = r_reg_write;
    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;
    assign bus.grant_id   = r_grant_id;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - vector table plus scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int NR = 3;
    localparam int DW = 16;
    localparam int AW = 4;

    localparam logic [NR*AW-1:0] A_RR = {4'd3, 4'd2, 4'd1};
    localparam logic [NR*DW-1:0] D_RR = {16'h3333, 16'h2222, 16'h1111};

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string            name;
        logic             stall;
        logic [NR-1:0]    valid;
        logic [NR*AW-1:0] addr;
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    exp_ready;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] wreg;
        logic [DW-1:0] wdata;
        logic [1:0]    id;
    } exp_t;

    vec_t          vecs[$];
    exp_t          sb[$];
    exp_t          last_exp;
    logic [DW-1:0] rf[16];
    logic [NR-1:0] pend_valid;
    logic [NR*AW-1:0] pend_addr;
    logic [NR*DW-1:0] pend_data;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic add_vec(input string name, input logic st, input logic [NR-1:0] v,
                           input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d,
                           input logic [NR-1:0] r);
        vec_t t;
        t.name = name; t.stall = st; t.valid = v; t.addr = a; t.data = d; t.exp_ready = r;
        vecs.push_back(t);
    endtask

    task automatic check_stable(input vec_t t);
        for (int i = 0; i < NR; i++) begin
            if (pend_valid[i] && (!t.valid[i] || t.addr[i*AW +: AW] != pend_addr[i*AW +: AW]
                                  || t.data[i*DW +: DW] != pend_data[i*DW +: DW])) begin
                failures++;
                $display("FAIL %s.protocol requester=%0d withdrew or changed before ready", t.name, i);
            end
        end
    endtask

    task automatic apply(input vec_t t);
        exp_t e;
        check_stable(t);
        bus.stall     = t.stall;
        bus.req_valid = t.valid;
        bus.req_addr  = t.addr;
        bus.req_data  = t.data;
        @(negedge clk);
        chk({t.name, ".ready"}, 64'(bus.req_ready), 64'(t.exp_ready));
        pend_valid = t.valid & ~bus.req_ready;
        pend_addr  = t.addr;
        pend_data  = t.data;
        e    = last_exp;
        e.we = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (t.exp_ready[i]) begin
                e.wreg  = t.addr[i*AW +: AW];
                e.wdata = t.data[i*DW +: DW];
                e.id    = 2'(i);
                e.we    = (e.wreg != '0);
            end
        end
        last_exp = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s.scoreboard actual=empty required=entry", t.name);
        end else begin
            e = sb.pop_front();
            chk({t.name, ".reg_write"},  64'(bus.reg_write),  64'(e.we));
            chk({t.name, ".write_reg"},  64'(bus.write_reg),  64'(e.wreg));
            chk({t.name, ".write_data"}, 64'(bus.write_data), 64'(e.wdata));
            chk({t.name, ".grant_id"},   64'(bus.grant_id),   64'(e.id));
        end
        if (bus.reg_write) rf[bus.write_reg] = bus.write_data;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = '0;
        last_exp   = '{we: 1'b0, wreg: '0, wdata: '0, id: 2'd0};
        pend_valid = '0;
        pend_addr  = '0;
        pend_data  = '0;

        add_vec("single",  1'b0, 3'b001, {4'd0, 4'd0, 4'd5}, {16'h0, 16'h0, 16'h1234}, 3'b001);
        add_vec("req2",    1'b0, 3'b100, {4'd9, 4'd0, 4'd0}, {16'h0909, 16'h0, 16'h0}, 3'b100);
        add_vec("idle0",   1'b0, 3'b000, '0, '0, 3'b000);
        add_vec("rr0",     1'b0, 3'b111, A_RR, D_RR, 3'b001);
        add_vec("rr1",     1'b0, 3'b111, A_RR, D_RR, 3'b010);
        add_vec("rr2",     1'b0, 3'b111, A_RR, D_RR, 3'b100);
        add_vec("rr3",     1'b0, 3'b111, A_RR, D_RR, 3'b001);
        add_vec("rr4",     1'b0, 3'b111, A_RR, D_RR, 3'b010);
        add_vec("rr5",     1'b0, 3'b111, A_RR, D_RR, 3'b100);
        add_vec("stall0",  1'b1, 3'b111, A_RR, D_RR, 3'b000);
        add_vec("stall1",  1'b1, 3'b111, A_RR, D_RR, 3'b000);
        add_vec("stall2",  1'b1, 3'b111, A_RR, D_RR, 3'b000);
        add_vec("unstall", 1'b0, 3'b111, A_RR, D_RR, 3'b001);
        add_vec("drain1",  1'b0, 3'b110, A_RR, D_RR, 3'b010);
        add_vec("drain2",  1'b0, 3'b100, A_RR, D_RR, 3'b100);
        add_vec("r0drop",  1'b0, 3'b010, {4'd0, 4'd0, 4'd0}, {16'h0, 16'hFFFF, 16'h0}, 3'b010);
        add_vec("conf_a",  1'b0, 3'b101, {4'd7, 4'd0, 4'd7}, {16'h0002, 16'h0, 16'h0001}, 3'b100);
        add_vec("conf_b",  1'b0, 3'b001, {4'd7, 4'd0, 4'd7}, {16'h0002, 16'h0, 16'h0001}, 3'b001);
        add_vec("idle1",   1'b0, 3'b000, '0, '0, 3'b000);

        reset         = 1'b1;
        bus.stall     = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = A_RR;
        bus.req_data  = D_RR;
        @(negedge clk);
        chk("rst.ready",      64'(bus.req_ready),  64'd0);
        chk("rst.reg_write",  64'(bus.reg_write),  64'd0);
        chk("rst.write_reg",  64'(bus.write_reg),  64'd0);
        chk("rst.write_data", 64'(bus.write_data), 64'd0);
        chk("rst.grant_id",   64'(bus.grant_id),   64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[k]) apply(vecs[k]);

        chk("rf.r7_final", 64'(rf[7]), 64'h0001);
        chk("rf.r0_clean", 64'(rf[0]), 64'h0000);

        bus.stall     = 1'b0;
        bus.req_valid = 3'b001;
        bus.req_addr  = {4'd0, 4'd0, 4'd4};
        bus.req_data  = {16'h0, 16'h0, 16'hABCD};
        @(posedge clk);
        #1;
        chk("ar.pre_reg_write", 64'(bus.reg_write), 64'd1);
        chk("ar.pre_write_reg", 64'(bus.write_reg), 64'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.reg_write",  64'(bus.reg_write),  64'd0);
        chk("ar.write_reg",  64'(bus.write_reg),  64'd0);
        chk("ar.write_data", 64'(bus.write_data), 64'd0);
        chk("ar.grant_id",   64'(bus.grant_id),   64'd0);
        chk("ar.ready",      64'(bus.req_ready),  64'd0);
        bus.req_valid = 3'b111;
        bus.req_addr  = A_RR;
        bus.req_data  = D_RR;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ar.restart_ready", 64'(bus.req_ready), 64'b001);
        @(posedge clk);
        #1;
        chk("ar.restart_reg_write", 64'(bus.reg_write),  64'd1);
        chk("ar.restart_write_reg", 64'(bus.write_reg),  64'd1);
        chk("ar.restart_grant_id",  64'(bus.grant_id),   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 16x16 register file between NUM_REQ write-back requesters, for example the ALU, load unit and multiply unit.
- Arbitration is round-robin, using a valid/ready handshake on each requester.
- Drives the register file's reg_write, write_reg and write_data from a registered output stage, so write-back has one cycle of latency.
- Writes addressed to R0 are acknowledged to the requester but never reach the register file.

Parameters:
- NUM_REQ, default 3: number of requesters. Legal range is 2 to 4.
- DATA_WIDTH, default 16: write data width.
- ADDR_WIDTH, default 4: register index width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  when high, no grant is issued this cycle.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed destination indices; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NUM_REQ*DATA_WIDTH  packed write data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot grant, combinational.
- reg_write  output  1  registered write enable to the register file.
- write_reg  output  ADDR_WIDTH  registered destination index.
- write_data  output  DATA_WIDTH  registered write data.
- grant_id  output  2  registered index of the requester whose write is currently on the port.

Behaviour:
- Reset: asynchronous and active-high.
  - Clears reg_write, write_reg, write_data, grant_id and rr_ptr to 0.
  - A write pending in the output stage is discarded.
  - req_ready is forced to all-zero while reset is high.
- Grant selection (combinational):
  - When stall=0, search req_valid starting at index rr_ptr and wrapping modulo NUM_REQ.
  - The first set bit is the winner; its req_ready bit is 1 and all other bits are 0.
  - req_ready is all-zero when stall=1 or no request is valid.
  - req_ready never depends on req_addr or req_data.
- Handshake:
  - A transfer occurs in a cycle where req_valid[i]=1 and req_ready[i]=1.
  - A requester holds valid, addr and data stable until it sees ready.
  - Valid may not be withdrawn before the transfer. The arbiter does not check this; the bench does.
- Pointer:
  - On a transfer from requester i, rr_ptr becomes (i+1) mod NUM_REQ at the next edge.
  - rr_ptr is unchanged when there is no transfer.
  - Guarantee: with every requester continuously valid, each requester receives a grant at least once every NUM_REQ cycles.
- Output stage, for a transfer in cycle N with address A and data D from requester i:
  - If A != 0: at edge N+1, reg_write=1, write_reg=A, write_data=D, grant_id=i.
  - If A == 0: at edge N+1, reg_write=0. write_reg, write_data and grant_id still update to A, D and i. The requester is acknowledged normally and rr_ptr still advances.
- With no transfer in cycle N, reg_write=0 at N+1, and write_reg, write_data and grant_id hold their previous values.
- reg_write is high for exactly one cycle per non-R0 transfer. Back-to-back transfers produce back-to-back writes.
- Conflicting destinations:
  - If two requesters target the same register in the same cycle, only the winner transfers.
  - The loser writes in a later cycle, so the last write is the one granted later.
  - No merging or suppression of writes is performed.
- Stall:
  - Takes effect in the same cycle it is asserted.
  - An output-stage write already registered is not affected and still completes.
- Reset mid-operation: all state returns to its reset values immediately. Requesters re-arbitrate starting from index 0.

Optional Feature:
- Macro name: REGFILE_WB_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; requester 0 is highest and NUM_REQ-1 is lowest.
  - rr_ptr is not implemented, and the search always starts at 0.
  - All other behaviour is unchanged, including the R0 drop, stall and output stage.
- Undefined: round-robin arbitration as described under Behaviour.

Test Plan:
- Reset, then single write:
  - Stimulus: req_valid=001, req_addr[0]=5, req_data[0]=16'h1234, stall=0.
  - Required: req_ready=001 in cycle N; reg_write=1, write_reg=5, write_data=16'h1234, grant_id=0 in cycle N+1; then reg_write=0.
- Round-robin:
  - Stimulus: all three requesters held valid for 6 cycles, each with a distinct non-zero address.
  - Required: grant order 0,1,2,0,1,2 and six consecutive reg_write pulses.
  - With REGFILE_WB_ARB_FIXED_PRIO_EN defined: requester 0 is granted every cycle.
- R0 drop:
  - Stimulus: requester 1 writes addr=0, data=16'hFFFF.
  - Required: req_ready[1]=1, reg_write stays 0 at N+1, grant_id=1, and the next grant search starts at requester 2.
- Stall:
  - Stimulus: stall=1 for 3 cycles with req_valid=111.
  - Required: req_ready=000 and reg_write=0 from the cycle after the stall starts; the first grant after stall drops goes to rr_ptr.
- Same-destination conflict:
  - Stimulus: requesters 0 and 2 both target R7, with data 16'h0001 and 16'h0002, rr_ptr=2.
  - Required: R7 is written with 16'h0002, then 16'h0001; the final value is 16'h0001.
- Async reset mid-operation:
  - Stimulus: assert reset between clock edges while reg_write=1.
  - Required: reg_write, write_reg, write_data and grant_id go to 0 immediately without waiting for a clock edge; req_ready=000.
